pulse_arbiter: RTL and testbench

//  Shares one pulse-widening output among N_REQ requesters. Requests are strobed in and latched as pending.
//  A round-robin scheduler grants one pending request at a time and drives a single pulse of the

---
 rtl/pulse_arb_pkg.sv | 14 +
 rtl/pulse_arb_rr_pick.sv | 30 +++
 rtl/pulse_arbiter.sv | 149 ++++++++++++++
 tb/tb_pulse_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_arb_pkg.sv
// Shared types and helpers for the pulse arbiter.
// Included by pulse_arbiter and rr_pick through import pulse_arb_pkg::*.
package pulse_arb_pkg;

    typedef enum logic [1:0] {IDLE, PULSE, GAP} pa_state_e;

    localparam int OVF_W = 8;

    // A programmed width of zero still produces a one-cycle pulse.
    function automatic int unsigned clamp_w(input int unsigned w);
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pulse_arb_rr_pick.sv
// Combinational round-robin picker.
// Returns the first set pending bit strictly after i_ptr, wrapping around.
module rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_pend,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gntId,
    output logic          o_gntVld
);
    import pulse_arb_pkg::*;

    int w_idx;

    // Scan from farthest to nearest so the nearest candidate overwrites the rest.
    always_comb begin
        o_gntId  = '0;
        o_gntVld = 1'b0;
        w_idx    = 0;
        for (int k = N; k >= 1; k--) begin
            w_idx = (int'(i_ptr) + k) % N;
            if (i_pend[w_idx]) begin
                o_gntId  = IW'(w_idx);
                o_gntVld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_arbiter.sv
// Round-robin arbiter sharing one widened strobe output among N_REQ requesters.
// Optional per-requester drop counters are built when PULSE_ARB_OVF_CNT_EN is defined.
module pulse_arbiter #(
    parameter  int N_REQ = 4,
    parameter  int W_MAX = 15,
    parameter  int GAP   = 1,
    localparam int WW    = $clog2(W_MAX + 1),
    localparam int IW    = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ*WW-1:0] i_width,
`ifdef PULSE_ARB_OVF_CNT_EN
    input  logic                i_ovf_clr,
    output logic [N_REQ*8-1:0]  o_ovf_cnt,
`endif
    output logic                o_out,
    output logic [IW-1:0]       o_out_id,
    output logic                o_busy,
    output logic [N_REQ-1:0]    o_pend
);
    import pulse_arb_pkg::*;

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    pa_state_e        r_state, w_stateNxt;
    logic [WW-1:0]    r_cnt, w_cntNxt;
    logic [GW-1:0]    r_gcnt, w_gcntNxt;
    logic             r_out, w_outNxt;
    logic [IW-1:0]    r_outId, w_outIdNxt;
    logic [IW-1:0]    r_rrPtr, w_rrPtrNxt;
    logic [N_REQ-1:0] r_pend, w_clr;
    logic [IW-1:0]    w_gntId;
    logic             w_gntVld;
    logic             w_tryGrant;
    logic             w_grant;
    logic [WW-1:0]    w_gntWidth;

    rr_pick #(.N(N_REQ)) u_pick (
        .i_pend   (r_pend),
        .i_ptr    (r_rrPtr),
        .o_gntId  (w_gntId),
        .o_gntVld (w_gntVld)
    );

    assign w_gntWidth = i_width[int'(w_gntId)*WW +: WW];
    assign w_grant    = w_tryGrant & w_gntVld;
    assign w_clr      = w_grant ? ({{(N_REQ-1){1'b0}}, 1'b1} << w_gntId) : '0;

    // End of a pulse (GAP==0) or end of the guard gap fall straight into the grant decision.
    always_comb begin
        w_stateNxt = r_state;
        w_cntNxt   = r_cnt;
        w_gcntNxt  = r_gcnt;
        w_outNxt   = r_out;
        w_outIdNxt = r_outId;
        w_rrPtrNxt = r_rrPtr;
        w_tryGrant = 1'b0;
        case (r_state)
            IDLE: w_tryGrant = 1'b1;
            PULSE: begin
                if (r_cnt <= WW'(1)) begin
                    if (GAP == 0) begin
                        w_tryGrant = 1'b1;
                    end else begin
                        w_stateNxt = pulse_arb_pkg::GAP;
                        w_outNxt   = 1'b0;
                        w_gcntNxt  = GW'(GAP);
                    end
                end else begin
                    w_cntNxt = r_cnt - 1'b1;
                end
            end
            pulse_arb_pkg::GAP: begin
                if (r_gcnt <= GW'(1)) begin
                    w_tryGrant = 1'b1;
                end else begin
                    w_gcntNxt = r_gcnt - 1'b1;
                end
            end
            default: w_stateNxt = IDLE;
        endcase
        if (w_tryGrant) begin
            if (w_gntVld) begin
                w_stateNxt = PULSE;
                w_cntNxt   = WW'(clamp_w(32'(w_gntWidth)));
                w_outNxt   = 1'b1;
                w_outIdNxt = w_gntId;
                w_rrPtrNxt = w_gntId;
            end else begin
                w_stateNxt = IDLE;
                w_outNxt   = 1'b0;
                w_cntNxt   = '0;
                w_gcntNxt  = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_out   <= 1'b0;
            r_outId <= '0;
            r_rrPtr <= IW'(N_REQ - 1);
            r_pend  <= '0;
        end else begin
            r_state <= w_stateNxt;
            r_cnt   <= w_cntNxt;
            r_gcnt  <= w_gcntNxt;
            r_out   <= w_outNxt;
            r_outId <= w_outIdNxt;
            r_rrPtr <= w_rrPtrNxt;
            r_pend  <= (r_pend & ~w_clr) | i_req;
        end
    end

`ifdef PULSE_ARB_OVF_CNT_EN
    logic [N_REQ-1:0]            w_drop;
    logic [N_REQ-1:0][OVF_W-1:0] r_ovfCnt;

    // A request is dropped when its flag is already set and not being granted this edge.
    assign w_drop = i_req & r_pend & ~w_clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovfCnt <= '0;
        end else if (i_ovf_clr) begin
            r_ovfCnt <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_drop[i] && (r_ovfCnt[i] != {OVF_W{1'b1}})) begin
                    r_ovfCnt[i] <= r_ovfCnt[i] + 1'b1;
                end
            end
        end
    end

    assign o_ovf_cnt = r_ovfCnt;
`endif

    assign o_out    = r_out;
    assign o_out_id = r_outId;
    assign o_busy   = (r_state != IDLE);
    assign o_pend   = r_pend;

endmodule

// File: tb/tb_pulse_arbiter.sv
// Directed self-checking bench for pulse_arbiter (GAP=1 instance plus a GAP=0 instance).
// Builds with or without PULSE_ARB_OVF_CNT_EN.
module tb_pulse_arbiter;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [3:0]  req    = '0;
    logic [3:0]  req0   = '0;
    logic [15:0] width  = '0;
    logic [15:0] width0 = '0;
    logic        out, out0, busy, busy0;
    logic [1:0]  outId, outId0;
    logic [3:0]  pend, pend0;
`ifdef PULSE_ARB_OVF_CNT_EN
    logic        ovfClr  = 1'b0;
    logic        ovfClr0 = 1'b0;
    logic [31:0] ovfCnt, ovfCnt0;
`endif

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    pulse_arbiter #(.N_REQ(4), .W_MAX(15), .GAP(1)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req),
        .i_width  (width),
`ifdef PULSE_ARB_OVF_CNT_EN
        .i_ovf_clr(ovfClr),
        .o_ovf_cnt(ovfCnt),
`endif
        .o_out    (out),
        .o_out_id (outId),
        .o_busy   (busy),
        .o_pend   (pend)
    );

    pulse_arbiter #(.N_REQ(4), .W_MAX(15), .GAP(0)) u_dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    (req0),
        .i_width  (width0),
`ifdef PULSE_ARB_OVF_CNT_EN
        .i_ovf_clr(ovfClr0),
        .o_ovf_cnt(ovfCnt0),
`endif
        .o_out    (out0),
        .o_out_id (outId0),
        .o_busy   (busy0),
        .o_pend   (pend0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] r);
        req = r;
    endtask

    task automatic resetDut();
        rst_n = 1'b0;
        req   = '0;
        req0  = '0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [0:14] e2Out;
        int          e2Id[15];
        int          e2Pend[15];
        logic [0:4]  e5Out;
        int          e5Id[5];
        logic        sawHigh;
        logic        found;

        // Reset values
        stepCycle();
        checkOutput("rst_out", 32'(out), 32'd0);
        checkOutput("rst_id", 32'(outId), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_pend", 32'(pend), 32'd0);
        rst_n = 1'b1;
        stepCycle();

        // Single strobe, width 3; width change after grant must not matter
        $display("[TB] single strobe width 3");
        width = 16'h0003;
        applyStimulus(4'b0001);
        stepCycle();
        checkOutput("t1_pend", 32'(pend), 32'd1);
        checkOutput("t1_out_lat", 32'(out), 32'd0);
        applyStimulus(4'b0000);
        stepCycle();
        checkOutput("t1_out_c1", 32'(out), 32'd1);
        checkOutput("t1_id", 32'(outId), 32'd0);
        checkOutput("t1_busy", 32'(busy), 32'd1);
        checkOutput("t1_pend_clr", 32'(pend), 32'd0);
        width = 16'h0001;
        stepCycle();
        checkOutput("t1_out_c2", 32'(out), 32'd1);
        stepCycle();
        checkOutput("t1_out_c3", 32'(out), 32'd1);
        stepCycle();
        checkOutput("t1_out_end", 32'(out), 32'd0);
        checkOutput("t1_busy_gap", 32'(busy), 32'd1);
        stepCycle();
        checkOutput("t1_busy_idle", 32'(busy), 32'd0);

        // All four at once, widths 1..4, one low cycle between pulses
        $display("[TB] four simultaneous requests");
        resetDut();
        e2Out  = 15'b010110111011110;
        e2Id   = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 2, 3, 3, 3, 3, 3};
        e2Pend = '{15, 14, 14, 12, 12, 12, 8, 8, 8, 8, 0, 0, 0, 0, 0};
        width  = {4'd4, 4'd3, 4'd2, 4'd1};
        applyStimulus(4'b1111);
        for (int i = 0; i < 15; i++) begin
            stepCycle();
            if (i == 0) applyStimulus(4'b0000);
            checkOutput($sformatf("t2_out_%0d", i), 32'(out), 32'(e2Out[i]));
            checkOutput($sformatf("t2_id_%0d", i), 32'(outId), 32'(e2Id[i]));
            checkOutput($sformatf("t2_pend_%0d", i), 32'(pend), 32'(e2Pend[i]));
        end

        // Round-robin fairness: after id 2, ids 3 then 0
        $display("[TB] round robin order");
        resetDut();
        width = 16'h1111;
        applyStimulus(4'b0100);
        stepCycle();
        applyStimulus(4'b1001);
        stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t3_id2", 32'(outId), 32'd2);
        checkOutput("t3_pend9", 32'(pend), 32'd9);
        stepCycle();
        checkOutput("t3_gap1", 32'(out), 32'd0);
        stepCycle();
        checkOutput("t3_out3", 32'(out), 32'd1);
        checkOutput("t3_id3", 32'(outId), 32'd3);
        checkOutput("t3_pend1", 32'(pend), 32'd1);
        stepCycle();
        stepCycle();
        checkOutput("t3_id0", 32'(outId), 32'd0);
        checkOutput("t3_pend0", 32'(pend), 32'd0);

        // Overflow: req[1] held 5 cycles while id 0 pulses for 8
        $display("[TB] overflow drops");
        resetDut();
        width = 16'h0008;
        applyStimulus(4'b0001);
        stepCycle();
        applyStimulus(4'b0010);
        for (int i = 0; i < 5; i++) stepCycle();
        applyStimulus(4'b0000);
        checkOutput("t4_out", 32'(out), 32'd1);
        checkOutput("t4_pend", 32'(pend), 32'd2);
`ifdef PULSE_ARB_OVF_CNT_EN
        checkOutput("t4_ovf1", ovfCnt[15:8], 32'd4);
        checkOutput("t4_ovf0", ovfCnt[7:0], 32'd0);
        ovfClr = 1'b1;
        stepCycle();
        ovfClr = 1'b0;
        checkOutput("t4_ovf_clr", ovfCnt, 32'd0);
`endif
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            stepCycle();
            if (out && outId == 2'd1) found = 1'b1;
        end
        checkOutput("t4_id1_granted", 32'(found), 32'd1);
        checkOutput("t4_pend_after", 32'(pend), 32'd0);

        // GAP=0 instance: back-to-back width-2 pulses
        $display("[TB] back to back with no gap");
        resetDut();
        e5Out  = 5'b11110;
        e5Id   = '{0, 0, 1, 1, 1};
        width0 = 16'h0022;
        req0   = 4'b0011;
        stepCycle();
        req0 = 4'b0000;
        checkOutput("t5_pend", 32'(pend0), 32'd3);
        for (int i = 0; i < 5; i++) begin
            stepCycle();
            checkOutput($sformatf("t5_out_%0d", i), 32'(out0), 32'(e5Out[i]));
            checkOutput($sformatf("t5_id_%0d", i), 32'(outId0), 32'(e5Id[i]));
        end
        checkOutput("t5_busy", 32'(busy0), 32'd0);

        // Reset in the middle of a width-5 pulse with another request pending
        $display("[TB] reset mid pulse");
        resetDut();
        width = 16'h0005;
        applyStimulus(4'b0001);
        stepCycle();
        applyStimulus(4'b0010);
        stepCycle();
        applyStimulus(4'b0000);
        stepCycle();
        checkOutput("t6_out_pre", 32'(out), 32'd1);
        checkOutput("t6_pend_pre", 32'(pend), 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_out_rst", 32'(out), 32'd0);
        checkOutput("t6_pend_rst", 32'(pend), 32'd0);
        checkOutput("t6_busy_rst", 32'(busy), 32'd0);
        #1;
        rst_n = 1'b1;
        sawHigh = 1'b0;
        for (int i = 0; i < 8; i++) begin
            stepCycle();
            sawHigh = sawHigh | out;
        end
        checkOutput("t6_no_pulse", 32'(sawHigh), 32'd0);

        // Width 0 clamps to a single cycle
        $display("[TB] zero width");
        resetDut();
        width = 16'h0000;
        applyStimulus(4'b0100);
        stepCycle();
        applyStimulus(4'b0000);
        stepCycle();
        checkOutput("t7_out", 32'(out), 32'd1);
        checkOutput("t7_id", 32'(outId), 32'd2);
        stepCycle();
        checkOutput("t7_out_end", 32'(out), 32'd0);
        checkOutput("t7_busy_gap", 32'(busy), 32'd1);
        stepCycle();
        checkOutput("t7_busy_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
